sbox_gen: RTL and testbench

//  Builds a BIT_WIDTH-bit bijective S-box and its inverse from a stream of chaotic samples: first

---
 rtl/sbox_gen.sv | 160 ++++++++++++++++
 tb/tb_sbox_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_gen.sv
// sbox_gen: builds a bijective S-box and its inverse from a chaotic sample stream.
// First occurrence of each value is kept; a long run of duplicates triggers an in-order auto-fill.
module sbox_gen #(
   parameter int BIT_WIDTH  = 8,
   parameter int MAX_REJECT = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 restart,
   input  logic                 tvalid,
   output logic                 tready,
   input  logic [BIT_WIDTH-1:0] V,
   input  logic                 lk_valid,
   input  logic                 lk_inv,
   input  logic [BIT_WIDTH-1:0] lk_addr,
   output logic                 lk_rvalid,
   output logic [BIT_WIDTH-1:0] lk_data,
   output logic [BIT_WIDTH:0]   count,
   output logic                 filled,
   output logic                 done_sbox
);

   localparam int SIZE = 1 << BIT_WIDTH;
   localparam int IW   = BIT_WIDTH + 1;
   localparam int RW   = $clog2(MAX_REJECT + 1);

   localparam logic [IW-1:0] LAST     = IW'(SIZE - 1);
   localparam logic [RW-1:0] REJ_LAST = RW'(MAX_REJECT - 1);
   localparam logic [RW-1:0] REJ_MAX  = RW'(MAX_REJECT);

   typedef enum logic [1:0] {
      CLEAR,
      COLLECT,
      FILL,
      DONE
   } state_t;

   state_t state;

   logic [BIT_WIDTH-1:0] fwd [SIZE];
   logic [BIT_WIDTH-1:0] inv [SIZE];
   logic [SIZE-1:0]      used;

   logic [IW-1:0]        ptr;
   logic [RW-1:0]        rej_cnt;
   logic [BIT_WIDTH-1:0] idx;
   logic [BIT_WIDTH-1:0] wr_val;
   logic                 wr_en;
   logic                 accept;
   logic                 lk_hit;

   assign idx    = ptr[BIT_WIDTH-1:0];
   assign accept = tvalid && tready;
   assign lk_hit = lk_valid && (state == DONE) && !restart;

   // One write port shared by the sample path and the fill scan.
   always_comb begin
      wr_en  = 1'b0;
      wr_val = V;
      if (!restart) begin
         unique case (state)
            COLLECT: wr_en = accept && !used[V];
            FILL: begin
               wr_val = idx;
               wr_en  = !used[idx];
            end
            default: wr_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         fwd[count[BIT_WIDTH-1:0]] <= wr_val;
         inv[wr_val]               <= count[BIT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         used[idx] <= 1'b0;
      end else if (wr_en) begin
         used[wr_val] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CLEAR;
         ptr       <= '0;
         count     <= '0;
         rej_cnt   <= '0;
         filled    <= 1'b0;
         tready    <= 1'b0;
         done_sbox <= 1'b0;
      end else if (restart) begin
         state     <= CLEAR;
         ptr       <= '0;
         count     <= '0;
         rej_cnt   <= '0;
         filled    <= 1'b0;
         tready    <= 1'b0;
         done_sbox <= 1'b0;
      end else begin
         unique case (state)
            CLEAR: begin
               ptr <= ptr + IW'(1);
               if (ptr == LAST) begin
                  state   <= COLLECT;
                  ptr     <= '0;
                  count   <= '0;
                  rej_cnt <= '0;
                  tready  <= 1'b1;
               end
            end
            COLLECT: begin
               if (accept && wr_en) begin
                  count   <= count + IW'(1);
                  rej_cnt <= '0;
                  if (count == LAST) begin
                     state     <= DONE;
                     tready    <= 1'b0;
                     done_sbox <= 1'b1;
                  end
               end else if (accept) begin
                  if (rej_cnt != REJ_MAX) rej_cnt <= rej_cnt + RW'(1);
                  if (rej_cnt == REJ_LAST) begin
                     state  <= FILL;
                     tready <= 1'b0;
                     ptr    <= '0;
                  end
               end
            end
            FILL: begin
               ptr <= ptr + IW'(1);
               if (wr_en) count <= count + IW'(1);
               if (ptr == LAST) begin
                  state     <= DONE;
                  filled    <= 1'b1;
                  done_sbox <= 1'b1;
               end
            end
            DONE: begin
            end
         endcase
      end
   end

   // Lookup data holds its last value while no request is served.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lk_rvalid <= 1'b0;
         lk_data   <= '0;
      end else begin
         lk_rvalid <= lk_hit;
         if (lk_hit) lk_data <= lk_inv ? inv[lk_addr] : fwd[lk_addr];
      end
   end

endmodule

// File: tb/tb_sbox_gen.sv
// tb_sbox_gen: directed bench for sbox_gen with BIT_WIDTH=4, MAX_REJECT=4.
// Expected tables are hand-derived from the stimulus streams.
module tb_sbox_gen;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       restart;
   logic       tvalid;
   logic       tready;
   logic [3:0] V;
   logic       lk_valid;
   logic       lk_inv;
   logic [3:0] lk_addr;
   logic       lk_rvalid;
   logic [3:0] lk_data;
   logic [4:0] count;
   logic       filled;
   logic       done_sbox;

   int tests = 0;
   int errs  = 0;
   int n;

   int seq_b [18] = '{3, 3, 7, 3, 0, 1, 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15};
   int fwd_b [16] = '{3, 7, 0, 1, 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15};
   int part  [6]  = '{1, 2, 4, 6, 7, 9};

   sbox_gen #(
      .BIT_WIDTH (4),
      .MAX_REJECT(4)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .restart  (restart),
      .tvalid   (tvalid),
      .tready   (tready),
      .V        (V),
      .lk_valid (lk_valid),
      .lk_inv   (lk_inv),
      .lk_addr  (lk_addr),
      .lk_rvalid(lk_rvalid),
      .lk_data  (lk_data),
      .count    (count),
      .filled   (filled),
      .done_sbox(done_sbox)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      tvalid = 1'b1;
      V      = v[3:0];
      tick();
      tvalid = 1'b0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!tready && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic lookup(input bit sel, input int addr, input int exp, input string tag);
      lk_valid = 1'b1;
      lk_inv   = sel;
      lk_addr  = addr[3:0];
      tick();
      lk_valid = 1'b0;
      check({tag, "_rv"}, lk_rvalid, 1);
      check(tag, lk_data, exp);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n  = 1'b0;
      restart  = 1'b0;
      tvalid   = 1'b0;
      V        = '0;
      lk_valid = 1'b0;
      lk_inv   = 1'b0;
      lk_addr  = '0;
      repeat (3) tick();
      check("rst_tready", tready, 0);
      check("rst_count", count, 0);
      check("rst_done", done_sbox, 0);
      check("rst_filled", filled, 0);
      check("rst_rvalid", lk_rvalid, 0);
      check("rst_data", lk_data, 0);

      // Power-on clear sweep
      reset_n = 1'b1;
      wait_ready(n);
      check("clear_len", n, 16);
      check("clear_done", done_sbox, 0);
      check("clear_count", count, 0);

      // Stream with duplicates
      for (int i = 0; i < 18; i++) begin
         send(seq_b[i]);
         if (i == 16) begin
            check("pre_count", count, 15);
            check("pre_done", done_sbox, 0);
         end
      end
      check("b_done", done_sbox, 1);
      check("b_count", count, 16);
      check("b_filled", filled, 0);
      check("b_tready", tready, 0);
      send(2);
      check("b_frozen", count, 16);
      lookup(1'b0, 0, 3, "b_fwd0");
      lookup(1'b0, 1, 7, "b_fwd1");
      lookup(1'b0, 2, 0, "b_fwd2");
      lookup(1'b1, 7, 1, "b_inv7");
      tick();
      check("hold_rv", lk_rvalid, 0);
      check("hold_data", lk_data, 1);

      // Back-to-back inverse lookups
      for (int i = 0; i < 16; i++) begin
         lk_valid = 1'b1;
         lk_inv   = 1'b1;
         lk_addr  = fwd_b[i][3:0];
         tick();
         check($sformatf("b2b_rv%0d", i), lk_rvalid, 1);
         check($sformatf("b2b_inv%0d", i), lk_data, i);
      end
      lk_valid = 1'b0;

      // Restart from DONE
      pulse_restart();
      check("rs_tready", tready, 0);
      check("rs_done", done_sbox, 0);
      check("rs_count", count, 0);
      wait_ready(n);
      check("rs_clear_len", n, 16);
      lk_valid = 1'b1;
      lk_inv   = 1'b0;
      lk_addr  = '0;
      tick();
      tick();
      lk_valid = 1'b0;
      check("collect_lk_rv", lk_rvalid, 0);
      send(3);
      check("reaccept3", count, 1);
      for (int i = 0; i < 6; i++) send(part[i]);
      check("part_count", count, 7);

      // Restart with an in-flight sample
      restart = 1'b1;
      tvalid  = 1'b1;
      V       = 4'd8;
      tick();
      restart = 1'b0;
      tvalid  = 1'b0;
      check("rs2_count", count, 0);
      check("rs2_tready", tready, 0);
      wait_ready(n);
      check("rs2_clear_len", n, 16);

      // Duplicate run with an idle gap, then auto-fill
      send(5);
      send(5);
      send(5);
      tick();
      check("gap_tready", tready, 1);
      send(5);
      check("rej3_tready", tready, 1);
      send(5);
      check("fill_tready", tready, 0);
      check("fill_count", count, 1);
      check("fill_done0", done_sbox, 0);
      repeat (15) tick();
      check("fill_early", done_sbox, 0);
      tick();
      check("fill_done", done_sbox, 1);
      check("fill_filled", filled, 1);
      check("fill_count16", count, 16);
      lookup(1'b0, 0, 5, "f_fwd0");
      lookup(1'b0, 1, 0, "f_fwd1");
      lookup(1'b0, 5, 4, "f_fwd5");
      lookup(1'b0, 6, 6, "f_fwd6");
      lookup(1'b0, 15, 15, "f_fwd15");
      lookup(1'b1, 5, 0, "f_inv5");
      lookup(1'b1, 6, 6, "f_inv6");
      lookup(1'b1, 0, 1, "f_inv0");

      // Async reset in the middle of FILL
      pulse_restart();
      check("rs3_filled", filled, 0);
      wait_ready(n);
      check("rs3_clear_len", n, 16);
      for (int i = 0; i < 9; i++) send(i);
      repeat (4) send(0);
      check("mf_tready", tready, 0);
      check("mf_count", count, 9);
      repeat (3) tick();
      check("mf_count_hold", count, 9);
      reset_n = 1'b0;
      #1;
      check("ar_done", done_sbox, 0);
      check("ar_filled", filled, 0);
      check("ar_count", count, 0);
      check("ar_tready", tready, 0);
      tick();
      reset_n = 1'b1;
      wait_ready(n);
      check("ar_clear_len", n, 16);
      check("ar_count2", count, 0);
      send(0);
      check("ar_empty", count, 1);

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
